// File: rtl/gpio_pkg.sv
// Shared definitions for the apb4_gpio_ext GPIO controller: register byte
// offsets, the interrupt-mode encoding and the default debounce width.
package gpio_pkg;

    localparam int GPIO_DB_W_DEFAULT = 16;

    localparam logic [5:0] OFF_DIR     = 6'h00;
    localparam logic [5:0] OFF_IN      = 6'h04;
    localparam logic [5:0] OFF_OUT     = 6'h08;
    localparam logic [5:0] OFF_OUTSET  = 6'h0C;
    localparam logic [5:0] OFF_OUTCLR  = 6'h10;
    localparam logic [5:0] OFF_INTEN   = 6'h14;
    localparam logic [5:0] OFF_INTTYPE = 6'h18;
    localparam logic [5:0] OFF_INTPOL  = 6'h1C;
    localparam logic [5:0] OFF_INTBOTH = 6'h20;
    localparam logic [5:0] OFF_INTSTAT = 6'h24;
    localparam logic [5:0] OFF_IOFCFG  = 6'h28;
    localparam logic [5:0] OFF_DBCFG   = 6'h2C;

    // INTTYPE / INTPOL bit meanings
    localparam logic INTTYPE_LEVEL = 1'b0;
    localparam logic INTPOL_HIGH   = 1'b1;

    // The five per-pin interrupt modes the three config bits can select
    typedef enum logic [2:0] {
        MODE_LEVEL_LOW  = 3'd0,
        MODE_LEVEL_HIGH = 3'd1,
        MODE_FALL       = 3'd2,
        MODE_RISE       = 3'd3,
        MODE_BOTH       = 3'd4
    } irq_mode_e;

    // Collapse INTTYPE/INTPOL/INTBOTH into one mode; INTPOL is a don't-care in both-edge mode
    function automatic irq_mode_e irq_mode(input logic itype, input logic ipol, input logic iboth);
        if (itype == INTTYPE_LEVEL) begin
            return (ipol == INTPOL_HIGH) ? MODE_LEVEL_HIGH : MODE_LEVEL_LOW;
        end
        if (iboth) begin
            return MODE_BOTH;
        end
        return (ipol == INTPOL_HIGH) ? MODE_RISE : MODE_FALL;
    endfunction

endpackage

// File: rtl/apb4_gpio_ext_if.sv
// APB4 slave bus bundle for apb4_gpio_ext (6-bit byte address, 32-bit data).
interface apb4_gpio_ext_if;

    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [5:0]  paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );

endinterface

// File: rtl/gpio_pin_filter.sv
// Per-pin input path: synchroniser chain, optional debounce filter
// (GPIO_DEBOUNCE_EN), and the delayed filtered copy used for edge detection.
module gpio_pin_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int DB_W        = 16
) (
    input  logic            hclk,
    input  logic            hrst,
    input  logic            i_pin,
    input  logic [DB_W-1:0] i_thr,
    output logic            o_filt,
    output logic            o_rise,
    output logic            o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_filt_d;
    logic                   w_sync;
    logic                   w_filt;

    // Shift the asynchronous pad value through the synchroniser flops
    always_ff @(posedge hclk) begin
        if (hrst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin};
        end
    end

    assign w_sync = r_sync[SYNC_STAGES-1];

`ifdef GPIO_DEBOUNCE_EN
    logic [DB_W-1:0] r_cnt;
    logic            r_filt;
    logic [DB_W-1:0] w_lim;

    // A threshold of 0 behaves like 1, so the limit never underflows
    assign w_lim = (i_thr == '0) ? '0 : (i_thr - DB_W'(1));

    // Count consecutive disagreeing cycles; toggle once the run is long enough.
    // The >= compare lets a lowered threshold act on an in-flight count at once.
    always_ff @(posedge hclk) begin
        if (hrst) begin
            r_cnt  <= '0;
            r_filt <= 1'b0;
        end else if (w_sync == r_filt) begin
            r_cnt <= '0;
        end else if (r_cnt >= w_lim) begin
            r_filt <= ~r_filt;
            r_cnt  <= '0;
        end else begin
            r_cnt <= r_cnt + DB_W'(1);
        end
    end

    assign w_filt = r_filt;
`else
    logic w_thr_unused;

    assign w_thr_unused = ^i_thr;
    assign w_filt       = w_sync;
`endif

    // Remember last cycle's filtered value for edge detection
    always_ff @(posedge hclk) begin
        if (hrst) begin
            r_filt_d <= 1'b0;
        end else begin
            r_filt_d <= w_filt;
        end
    end

    assign o_filt = w_filt;
    assign o_rise = w_filt & ~r_filt_d;
    assign o_fall = ~w_filt & r_filt_d;

endmodule

// File: rtl/apb4_gpio_ext.sv
// APB4 GPIO controller: direction/output/IO-function registers, filtered
// inputs, five interrupt modes with sticky W1C pending bits, one level irq.
// Build option: define GPIO_DEBOUNCE_EN to add the per-pin debounce filter
// and a live DBCFG register; otherwise DBCFG reads 0 but stays mapped.
module apb4_gpio_ext
    import gpio_pkg::*;
#(
    parameter int GPIO_NUM    = 32,
    parameter int SYNC_STAGES = 2,
    parameter int DB_W        = GPIO_DB_W_DEFAULT
) (
    input  logic                hclk,
    input  logic                hrst,
    apb4_gpio_ext_if.slave      apb,
    input  logic [GPIO_NUM-1:0] gpio_in_i,
    output logic [GPIO_NUM-1:0] gpio_in_sync_o,
    output logic [GPIO_NUM-1:0] gpio_out_o,
    output logic [GPIO_NUM-1:0] gpio_dir_o,
    output logic [GPIO_NUM-1:0] gpio_iof_o,
    output logic                irq_o
);

    typedef logic [GPIO_NUM-1:0] pins_t;

    pins_t r_dir, r_out, r_inten, r_type, r_pol, r_both, r_iof, r_pend;
    logic  r_irq;

    pins_t           w_filt, w_rise, w_fall, w_event, w_wdata, w_w1c;
    logic [5:0]      w_off;
    logic            w_access, w_wr, w_mapped;
    logic [31:0]     w_rdata;
    logic [DB_W-1:0] w_thr;
    logic            w_unused;

    // Pin-wide register value placed in the low bits of a 32-bit bus word
    function automatic logic [31:0] ext(input pins_t v);
        logic [31:0] r;
        r               = '0;
        r[GPIO_NUM-1:0] = v;
        return r;
    endfunction

    assign w_off    = {apb.paddr[5:2], 2'b00};
    assign w_access = apb.psel & apb.penable;
    assign w_wr     = w_access & apb.pwrite;
    assign w_wdata  = apb.pwdata[GPIO_NUM-1:0];
    // Byte-lane bits and data bits above the pin count carry no meaning here
    assign w_unused = ^{apb.paddr[1:0], apb.pwdata};

`ifdef GPIO_DEBOUNCE_EN
    logic [DB_W-1:0] r_dbcfg;

    // Debounce threshold shared by all pins
    always_ff @(posedge hclk) begin
        if (hrst) begin
            r_dbcfg <= '0;
        end else if (w_wr && (w_off == OFF_DBCFG)) begin
            r_dbcfg <= apb.pwdata[DB_W-1:0];
        end
    end

    assign w_thr = r_dbcfg;
`else
    assign w_thr = '0;
`endif

    for (genvar g = 0; g < GPIO_NUM; g++) begin : g_pin
        gpio_pin_filter #(
            .SYNC_STAGES (SYNC_STAGES),
            .DB_W        (DB_W)
        ) u_filter (
            .hclk   (hclk),
            .hrst   (hrst),
            .i_pin  (gpio_in_i[g]),
            .i_thr  (w_thr),
            .o_filt (w_filt[g]),
            .o_rise (w_rise[g]),
            .o_fall (w_fall[g])
        );
    end

    // Read mux and unmapped-offset detection, purely from the address
    always_comb begin
        w_rdata  = '0;
        w_mapped = 1'b1;
        case (w_off)
            OFF_DIR:     w_rdata = ext(r_dir);
            OFF_IN:      w_rdata = ext(w_filt);
            OFF_OUT:     w_rdata = ext(r_out);
            OFF_OUTSET,
            OFF_OUTCLR:  w_rdata = '0;
            OFF_INTEN:   w_rdata = ext(r_inten);
            OFF_INTTYPE: w_rdata = ext(r_type);
            OFF_INTPOL:  w_rdata = ext(r_pol);
            OFF_INTBOTH: w_rdata = ext(r_both);
            OFF_INTSTAT: w_rdata = ext(r_pend);
            OFF_IOFCFG:  w_rdata = ext(r_iof);
`ifdef GPIO_DEBOUNCE_EN
            OFF_DBCFG:   w_rdata[DB_W-1:0] = r_dbcfg;
`else
            OFF_DBCFG:   w_rdata = '0;
`endif
            default:     w_mapped = 1'b0;
        endcase
    end

    assign apb.prdata  = w_rdata;
    assign apb.pready  = 1'b1;
    assign apb.pslverr = w_access & ~w_mapped;

    // Configuration and output-data registers; IN, INTSTAT and unmapped writes fall through
    always_ff @(posedge hclk) begin
        if (hrst) begin
            r_dir   <= '0;
            r_out   <= '0;
            r_inten <= '0;
            r_type  <= '0;
            r_pol   <= '0;
            r_both  <= '0;
            r_iof   <= '0;
        end else if (w_wr) begin
            case (w_off)
                OFF_DIR:     r_dir   <= w_wdata;
                OFF_OUT:     r_out   <= w_wdata;
                OFF_OUTSET:  r_out   <= r_out | w_wdata;
                OFF_OUTCLR:  r_out   <= r_out & ~w_wdata;
                OFF_INTEN:   r_inten <= w_wdata;
                OFF_INTTYPE: r_type  <= w_wdata;
                OFF_INTPOL:  r_pol   <= w_wdata;
                OFF_INTBOTH: r_both  <= w_wdata;
                OFF_IOFCFG:  r_iof   <= w_wdata;
                default: ;
            endcase
        end
    end

    // Per-pin interrupt event from the filtered input and its mode
    always_comb begin
        w_event = '0;
        for (int i = 0; i < GPIO_NUM; i++) begin
            case (irq_mode(r_type[i], r_pol[i], r_both[i]))
                MODE_LEVEL_LOW:  w_event[i] = ~w_filt[i];
                MODE_LEVEL_HIGH: w_event[i] = w_filt[i];
                MODE_FALL:       w_event[i] = w_fall[i];
                MODE_RISE:       w_event[i] = w_rise[i];
                MODE_BOTH:       w_event[i] = w_rise[i] | w_fall[i];
                default:         w_event[i] = 1'b0;
            endcase
        end
    end

    assign w_w1c = (w_wr && (w_off == OFF_INTSTAT)) ? w_wdata : '0;

    // Sticky pending bits: a same-cycle set beats the W1C, so held levels re-pend
    always_ff @(posedge hclk) begin
        if (hrst) begin
            r_pend <= '0;
        end else begin
            r_pend <= (r_pend & ~w_w1c) | (w_event & r_inten);
        end
    end

    // Interrupt line registered from the enabled pending bits
    always_ff @(posedge hclk) begin
        if (hrst) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= |(r_pend & r_inten);
        end
    end

    assign gpio_in_sync_o = w_filt;
    assign gpio_out_o     = r_out;
    assign gpio_dir_o     = r_dir;
    assign gpio_iof_o     = r_iof;
    assign irq_o          = r_irq;

endmodule

// File: tb/tb_apb4_gpio_ext.sv
// Self-checking bench for apb4_gpio_ext: directed scenarios with fixed
// expectations plus a randomized phase checked against a behavioural model.
module tb_apb4_gpio_ext;
    import gpio_pkg::*;

    localparam int N   = 32;
    localparam int S   = 2;
    localparam int DBW = 16;
`ifdef GPIO_DEBOUNCE_EN
    localparam bit DB_ON = 1'b1;
`else
    localparam bit DB_ON = 1'b0;
`endif
    localparam int D = DB_ON ? 4 : 0;

    logic         hclk = 1'b0;
    logic         hrst;
    logic [N-1:0] gpio_in;
    logic [N-1:0] in_sync, out_o, dir_o, iof_o;
    logic         irq;

    apb4_gpio_ext_if apb_if();

    apb4_gpio_ext #(
        .GPIO_NUM    (N),
        .SYNC_STAGES (S),
        .DB_W        (DBW)
    ) dut (
        .hclk           (hclk),
        .hrst           (hrst),
        .apb            (apb_if),
        .gpio_in_i      (gpio_in),
        .gpio_in_sync_o (in_sync),
        .gpio_out_o     (out_o),
        .gpio_dir_o     (dir_o),
        .gpio_iof_o     (iof_o),
        .irq_o          (irq)
    );

    always #5 hclk = ~hclk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Behavioural model: registers as plain words, synchroniser as an S-deep
    // history of sampled pad values, debounce as a per-pin run length.
    logic [31:0]  m_dir, m_out, m_inten, m_type, m_pol, m_both, m_iof, m_pend;
    int           m_db;
    logic         m_irq;
    logic [N-1:0] m_filt, m_filt_d;
    int           m_run [N];
    logic [N-1:0] m_hist [$];

    task automatic model_reset();
        m_dir = 0; m_out = 0; m_inten = 0; m_type = 0; m_pol = 0; m_both = 0;
        m_iof = 0; m_pend = 0; m_db = 0; m_irq = 1'b0; m_filt = '0; m_filt_d = '0;
        for (int i = 0; i < N; i++) m_run[i] = 0;
        m_hist.delete();
        for (int k = 0; k < S; k++) m_hist.push_back('0);
    endtask

    task automatic model_step();
        logic [N-1:0] sync_pre, ev;
        logic [31:0]  w1c;
        logic         rise, fall, wr;
        int           thr;
        if (hrst) begin
            model_reset();
            return;
        end
        sync_pre = m_hist[0];
        thr = (m_db < 1) ? 1 : m_db;
        wr  = apb_if.psel && apb_if.penable && apb_if.pwrite;
        ev  = '0;
        for (int i = 0; i < N; i++) begin
            rise = m_filt[i] && !m_filt_d[i];
            fall = !m_filt[i] && m_filt_d[i];
            if (!m_type[i]) ev[i] = (m_filt[i] == m_pol[i]);
            else if (m_both[i]) ev[i] = rise || fall;
            else ev[i] = m_pol[i] ? rise : fall;
        end
        w1c = (wr && apb_if.paddr == OFF_INTSTAT) ? apb_if.pwdata : 32'h0;
        m_irq = |(m_pend & m_inten);
        m_pend = (m_pend & ~w1c) | (32'(ev) & m_inten);
        m_filt_d = m_filt;
        void'(m_hist.pop_front());
        m_hist.push_back(gpio_in);
        if (DB_ON) begin
            for (int i = 0; i < N; i++) begin
                if (sync_pre[i] != m_filt[i]) begin
                    m_run[i]++;
                    if (m_run[i] >= thr) begin
                        m_filt[i] = ~m_filt[i];
                        m_run[i]  = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
        end else begin
            m_filt = m_hist[0];
        end
        if (wr) begin
            case (apb_if.paddr)
                OFF_DIR:     m_dir   = apb_if.pwdata;
                OFF_OUT:     m_out   = apb_if.pwdata;
                OFF_OUTSET:  m_out   = m_out | apb_if.pwdata;
                OFF_OUTCLR:  m_out   = m_out & ~apb_if.pwdata;
                OFF_INTEN:   m_inten = apb_if.pwdata;
                OFF_INTTYPE: m_type  = apb_if.pwdata;
                OFF_INTPOL:  m_pol   = apb_if.pwdata;
                OFF_INTBOTH: m_both  = apb_if.pwdata;
                OFF_IOFCFG:  m_iof   = apb_if.pwdata;
                OFF_DBCFG:   if (DB_ON) m_db = int'(apb_if.pwdata[DBW-1:0]);
                default: ;
            endcase
        end
    endtask

    function automatic logic [31:0] model_read(input logic [5:0] a);
        case (a)
            OFF_DIR:     return m_dir;
            OFF_IN:      return 32'(m_filt);
            OFF_OUT:     return m_out;
            OFF_INTEN:   return m_inten;
            OFF_INTTYPE: return m_type;
            OFF_INTPOL:  return m_pol;
            OFF_INTBOTH: return m_both;
            OFF_INTSTAT: return m_pend;
            OFF_IOFCFG:  return m_iof;
            OFF_DBCFG:   return 32'(m_db);
            default:     return 32'h0;
        endcase
    endfunction

    task automatic tick();
        @(posedge hclk);
        model_step();
        #1;
    endtask

    task automatic apb_write(input logic [5:0] a, input logic [31:0] d);
        apb_if.psel = 1'b1; apb_if.penable = 1'b0; apb_if.pwrite = 1'b1;
        apb_if.paddr = a; apb_if.pwdata = d;
        tick();
        apb_if.penable = 1'b1;
        tick();
        apb_if.psel = 1'b0; apb_if.penable = 1'b0; apb_if.pwrite = 1'b0;
    endtask

    task automatic apb_read(input logic [5:0] a, output logic [31:0] d, output logic err,
                            output logic [31:0] exp);
        apb_if.psel = 1'b1; apb_if.penable = 1'b0; apb_if.pwrite = 1'b0; apb_if.paddr = a;
        tick();
        apb_if.penable = 1'b1;
        #1;
        d   = apb_if.prdata;
        err = apb_if.pslverr;
        exp = model_read(a);
        tick();
        apb_if.psel = 1'b0; apb_if.penable = 1'b0;
    endtask

    task automatic compare_outputs(input string tag);
        check_eq({tag, "_out"},  out_o,       m_out);
        check_eq({tag, "_dir"},  dir_o,       m_dir);
        check_eq({tag, "_iof"},  iof_o,       m_iof);
        check_eq({tag, "_sync"}, in_sync,     32'(m_filt));
        check_eq({tag, "_irq"},  32'(irq),    32'(m_irq));
    endtask

    logic [31:0] rd, mexp;
    logic        err;
    logic [5:0]  addr;
    int          pin;
    logic [5:0]  wr_addrs [11] = '{OFF_DIR, OFF_IN, OFF_OUT, OFF_OUTSET, OFF_OUTCLR, OFF_INTEN,
                                  OFF_INTTYPE, OFF_INTPOL, OFF_INTSTAT, OFF_IOFCFG, OFF_DBCFG};

    initial begin
        hrst = 1'b1; gpio_in = '0;
        apb_if.psel = 1'b0; apb_if.penable = 1'b0; apb_if.pwrite = 1'b0;
        apb_if.paddr = '0; apb_if.pwdata = '0;
        model_reset();
        repeat (3) tick();
        hrst = 1'b0;

        // Reset state
        check_eq("rst_out", out_o, 0);
        check_eq("rst_dir", dir_o, 0);
        check_eq("rst_iof", iof_o, 0);
        check_eq("rst_sync", in_sync, 0);
        check_eq("rst_irq", 32'(irq), 0);
        for (int a = 0; a < 12; a++) begin
            apb_read(6'(a * 4), rd, err, mexp);
            check_eq($sformatf("rst_rd_%02h", a * 4), rd, 0);
        end
        apb_read(6'h30, rd, err, mexp);
        check_eq("unmapped_err", 32'(err), 1);
        check_eq("unmapped_rd", rd, 0);
        apb_read(OFF_DBCFG, rd, err, mexp);
        check_eq("dbcfg_err", 32'(err), 0);

        // Output set/clear
        apb_write(OFF_OUT, 32'h0000_00F0);
        apb_write(OFF_OUTSET, 32'h0F);
        apb_write(OFF_OUTCLR, 32'h30);
        check_eq("out_pins", out_o, 32'hCF);
        apb_read(OFF_OUT, rd, err, mexp);    check_eq("out_rd", rd, 32'hCF);
        apb_read(OFF_OUTSET, rd, err, mexp); check_eq("outset_rd", rd, 0);
        apb_read(OFF_OUTCLR, rd, err, mexp); check_eq("outclr_rd", rd, 0);
        apb_write(OFF_IN, 32'hFFFF_FFFF);
        apb_read(OFF_IN, rd, err, mexp);     check_eq("in_wr_ignored", rd, 0);

        // Debounce and rising-edge interrupt on pin 0
        apb_write(OFF_DBCFG, 4);
        apb_read(OFF_DBCFG, rd, err, mexp);  check_eq("dbcfg_rd", rd, DB_ON ? 4 : 0);
        apb_write(OFF_INTTYPE, 32'h1);
        apb_write(OFF_INTPOL, 32'h1);
        apb_write(OFF_INTEN, 32'h1);
        gpio_in[0] = 1'b1;
        repeat (3) tick();
        gpio_in[0] = 1'b0;
        repeat (12) tick();
        apb_read(OFF_INTSTAT, rd, err, mexp);
        check_eq("glitch_pend", rd, DB_ON ? 0 : 1);
        check_eq("glitch_irq", 32'(irq), DB_ON ? 0 : 1);
        apb_write(OFF_INTSTAT, 32'h1);
        repeat (2) tick();
        check_eq("glitch_clr_irq", 32'(irq), 0);

        gpio_in[0] = 1'b1;
        repeat (S + D - 1) tick();
        check_eq("lat_sync_before", 32'(in_sync[0]), 0);
        tick();
        check_eq("lat_sync_after", 32'(in_sync[0]), 1);
        tick();
        check_eq("lat_irq_before", 32'(irq), 0);
        tick();
        check_eq("lat_irq_after", 32'(irq), 1);
        repeat (10 - (S + D + 2)) tick();
        apb_read(OFF_INTSTAT, rd, err, mexp); check_eq("long_pend", rd, 1);
        gpio_in[0] = 1'b0;
        apb_write(OFF_INTSTAT, 32'h1);
        repeat (S + D + 3) tick();
        apb_read(OFF_INTSTAT, rd, err, mexp); check_eq("fall_ignored", rd, 0);

        // Both-edge interrupt on pin 3
        apb_write(OFF_INTTYPE, 32'h9);
        apb_write(OFF_INTBOTH, 32'h8);
        apb_write(OFF_INTEN, 32'h9);
        gpio_in[3] = 1'b1;
        repeat (S + D + 4) tick();
        apb_read(OFF_INTSTAT, rd, err, mexp); check_eq("both_rise", rd, 32'h8);
        check_eq("both_irq", 32'(irq), 1);
        apb_write(OFF_INTSTAT, 32'h8);
        check_eq("w1c_irq_hold", 32'(irq), 1);
        tick();
        check_eq("w1c_irq_fall", 32'(irq), 0);
        gpio_in[3] = 1'b0;
        repeat (S + D + 4) tick();
        apb_read(OFF_INTSTAT, rd, err, mexp); check_eq("both_fall", rd, 32'h8);
        apb_write(OFF_INTSTAT, 32'h8);

        // Level-high on pin 5: set wins over W1C while the level holds
        apb_write(OFF_INTPOL, 32'h21);
        apb_write(OFF_INTEN, 32'h29);
        gpio_in[5] = 1'b1;
        repeat (S + D + 4) tick();
        apb_write(OFF_INTSTAT, 32'h20);
        apb_read(OFF_INTSTAT, rd, err, mexp); check_eq("level_set_wins", rd, 32'h20);
        check_eq("level_irq", 32'(irq), 1);
        gpio_in[5] = 1'b0;
        repeat (S + D + 3) tick();
        apb_write(OFF_INTSTAT, 32'h20);
        apb_read(OFF_INTSTAT, rd, err, mexp); check_eq("level_cleared", rd, 0);
        check_eq("level_irq_low", 32'(irq), 0);

        // Reset with a pending bit and a debounce in flight
        gpio_in[0] = 1'b1;
        repeat (S + D + 3) tick();
        apb_read(OFF_INTSTAT, rd, err, mexp); check_eq("pre_rst_pend", rd, 32'h1);
        gpio_in[3] = 1'b1;
        repeat (S + 1) tick();
        hrst = 1'b1;
        gpio_in = '0;
        tick();
        check_eq("mid_rst_out", out_o, 0);
        check_eq("mid_rst_dir", dir_o, 0);
        check_eq("mid_rst_iof", iof_o, 0);
        check_eq("mid_rst_sync", in_sync, 0);
        check_eq("mid_rst_irq", 32'(irq), 0);
        hrst = 1'b0;
        repeat (S + D + 6) tick();
        apb_read(OFF_INTSTAT, rd, err, mexp); check_eq("post_rst_pend", rd, 0);
        apb_read(OFF_DBCFG, rd, err, mexp);   check_eq("post_rst_dbcfg", rd, 0);
        check_eq("post_rst_irq", 32'(irq), 0);
        check_eq("post_rst_sync", in_sync, 0);

        // Randomized traffic against the model
        for (int it = 0; it < 400; it++) begin
            case ($urandom_range(0, 5))
                0, 1: begin
                    addr = wr_addrs[$urandom_range(0, 10)];
                    if (addr == OFF_DBCFG) apb_write(addr, 32'($urandom_range(0, 5)));
                    else apb_write(addr, $urandom);
                end
                2: begin
                    pin = int'($urandom_range(0, N - 1));
                    gpio_in[pin] = ~gpio_in[pin];
                    tick();
                end
                3: repeat ($urandom_range(1, 8)) tick();
                4: begin
                    addr = 6'($urandom_range(0, 12) * 4);
                    apb_read(addr, rd, err, mexp);
                    check_eq($sformatf("rnd_rd_%02h", addr), rd, mexp);
                    check_eq("rnd_err", 32'(err), (addr == 6'h30) ? 1 : 0);
                end
                default: begin
                    pin = int'($urandom_range(0, N - 1));
                    gpio_in[pin] = ~gpio_in[pin];
                    repeat ($urandom_range(1, 3)) tick();
                    gpio_in[pin] = ~gpio_in[pin];
                    tick();
                end
            endcase
            if (it % 8 == 0) compare_outputs("rnd");
        end
        compare_outputs("final");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/apb4_gpio_ext.md
# apb4_gpio_ext

Parametrised next-generation GPIO controller with a discrete APB4 slave port, 1–32 pins, configurable synchroniser depth, per-pin digital debounce, five interrupt modes and sticky per-pin pending bits with write-1-to-clear. It sits on the peripheral APB4 bus beside the other OSCC IP blocks. It drives the pad direction, output and IO-function-select lines, and raises one level interrupt to the platform interrupt controller.

## Interface
- GPIO_NUM, 32: number of pins, 1..32. Register bits at GPIO_NUM and above read 0 and ignore writes.
- SYNC_STAGES, 2: input synchroniser flops, 2..4.
- DB_W, 16: width of the debounce threshold and of the per-pin counters.
- hclk  in  1  the single clock.
- hrst  in  1  synchronous, active-high reset.
- psel, penable, pwrite  in  1 each  APB4 control.
- paddr  in  6  byte address; bits [5:2] select the register.
- pwdata  in  32  write data.
- prdata  out  32  read data; combinational from the address.
- pready  out  1  tied to 1.
- pslverr  out  1  1 during an access phase to an unmapped offset, otherwise 0.
- gpio_in_i  in  GPIO_NUM  raw pad inputs, asynchronous.
- gpio_in_sync_o, gpio_out_o, gpio_dir_o, gpio_iof_o  out  GPIO_NUM  filtered input, output data, direction (1 = output), IO-function select.
- irq_o  out  1  registered interrupt.

## Operation
- A write is taken when psel & penable & pwrite. A read is psel & penable & !pwrite.
- Register map (offset: name, access):
  - 0x00: DIR, rw.
  - 0x04: IN, ro; returns the filtered value.
  - 0x08: OUT, rw.
  - 0x0C: OUTSET, wo; OUT |= pwdata.
  - 0x10: OUTCLR, wo; OUT &= ~pwdata.
  - 0x14: INTEN, rw.
  - 0x18: INTTYPE, rw; 0 = level, 1 = edge.
  - 0x1C: INTPOL, rw; 0 = low/fall, 1 = high/rise.
  - 0x20: INTBOTH, rw; for an edge-type pin, 1 = both edges and INTPOL is ignored.
  - 0x24: INTSTAT, read gives pending bits, write 1 clears the bit.
  - 0x28: IOFCFG, rw.
  - 0x2C: DBCFG, rw, width DB_W.
  - All other offsets: unmapped.
- Write-only registers read 0.
- Writes to IN or to unmapped offsets change no register.
- Input path per pin: SYNC_STAGES flops, then the debounce filter, then the filtered value filt and a delayed copy filt_d.
- Debounce filter:
  - Counter clears whenever the synchronised value equals filt.
  - Counter increments while the synchronised value differs from filt.
  - filt toggles when the counter reaches max(DBCFG,1)-1, and the counter clears on the same edge.
  - A glitch shorter than max(DBCFG,1) cycles is rejected.
  - DBCFG changes take effect on in-flight counts immediately.
- Event per pin:
  - Level mode: filt == INTPOL.
  - Edge mode: rise is filt & ~filt_d; fall is ~filt & filt_d. Select by INTPOL, or take either when INTBOTH is set.
- pending[i] sets on an event when INTEN[i] = 1. It stays set until INTSTAT is written with bit i = 1.
- Set wins over a same-cycle W1C. A level interrupt therefore re-pends every cycle while its level holds.
- Clearing INTEN[i] does not clear pending[i], but it masks pin i from irq_o.
- irq_o <= |(pending & INTEN).
- Reads have no side effects.

## Timing
- On hrst, every register, synchroniser, filter, counter, pending bit and irq_o goes to 0. Every output is 0 after the reset edge.
- Reset asserted mid-debounce or mid-interrupt discards all state.
- Writes land on the hclk edge that ends the access phase. prdata reflects the register state at that time.
- A pin change that is stable before edge 0:
  - gpio_in_sync_o changes after SYNC_STAGES + D edges, where D = max(DBCFG,1) with the macro and 0 without it.
  - pending sets one edge later.
  - irq_o rises one edge after pending.
- After a W1C that leaves no enabled pending bits, irq_o falls on the next edge.

## Configuration
- GPIO_DEBOUNCE_EN defined:
  - Filter and per-pin counters are present.
  - DBCFG is mapped.
- GPIO_DEBOUNCE_EN undefined:
  - filt equals the last synchroniser stage, and no counters are built.
  - DBCFG reads 0, ignores writes, and stays mapped, so pslverr = 0.

## Structure
- Package gpio_pkg holds:
  - the register offset localparams;
  - the interrupt-mode encoding constants;
  - the default DB_W.
- Sub-module gpio_pin_filter, one per pin via generate. It contains the synchroniser chain, the debounce counter and filt/filt_d, and outputs filt, rise and fall.

## Test plan
- Reset, then read every offset → all 0. Access at 0x30 → pslverr = 1 with prdata 0.
- Write OUT = 0x0000_00F0, then OUTSET 0x0F, then OUTCLR 0x30 → gpio_out_o = 0xCF; OUTSET/OUTCLR read back 0.
- DBCFG = 4, pin 0 edge/rise, INTEN[0] = 1:
  - 3-cycle high pulse → no pending, irq_o = 0.
  - 10-cycle high → pending[0] = 1, irq_o = 1 at edge SYNC_STAGES + 4 + 2.
- Pin 3 INTBOTH = 1:
  - rise → INTSTAT reads 0x8;
  - W1C 0x8 → irq_o = 0 next edge;
  - fall → pending again.
- Pin 5 level-high, held high, W1C 0x20 → bit stays 1 (set wins). Drop pin, W1C → 0 and irq_o = 0.
- Assert hrst while pending = 0x1 and a debounce count is in flight → all outputs 0 next edge, no stale event afterwards.
